lifo_drain_ctrl: RTL and testbench
==================================

// Module: lifo_drain_ctrl
// PURPOSE
//  Burst drain controller placed downstream of a LIFO stack. On a command it pops up to N entries,
//  one at a time, and forwards each returned word, in pop order, onto a valid/ready output stream
//  through a 2-entry output buffer. It ends the burst early if the stack runs empty or a pop is never answered.
//  It reports completion, the number of words drained and an error flag.
// PARAMETERS
//  DATA_W     10  data word width
//  LIFO_SIZE  6   depth of the upstream stack; bounds cmd_len
//  TIMEOUT    15  max cycles to wait for stk_val after a pop pulse
//  CNT_W      $clog2(LIFO_SIZE+1)  width of length/count fields (derived)
// PORTS
//  clock      in   1       single clock, all logic rising-edge
//  reset_n    in   1       asynchronous, active-low reset
//  cmd_start  in   1       1-cycle command strobe; accepted only when cmd_busy=0
//  cmd_len    in   CNT_W   words to drain; values >LIFO_SIZE clamp to LIFO_SIZE
//  cmd_busy   out  1       high from the cycle after an accepted start until done
//  done       out  1       1-cycle pulse at burst end
//  done_cnt   out  CNT_W   words drained this burst; valid with done, held until next done
//  err        out  1       sticky timeout flag; cleared by next accepted cmd_start
//  stk_empty  in   1       stack empty indication
//  stk_pop    out  1       1-cycle pop request to the stack
//  stk_val    in   1       stack returns data this cycle
//  stk_data   in   DATA_W  returned word, sampled when stk_val=1
//  m_valid    out  1       output stream valid
//  m_ready    in   1       output stream ready
//  m_data     out  DATA_W  output stream data
// BEHAVIOUR
//  Reset (reset_n=0, async): state IDLE; all outputs 0; buffer emptied; counters 0; err 0; done_cnt 0.
//  FSM states are IDLE, ISSUE, WAIT and DONE.
//  IDLE:
//   - cmd_start=1: latch len=min(cmd_len,LIFO_SIZE), clear cnt and err.
//   - Go to DONE if len=0, otherwise go to ISSUE.
//  ISSUE:
//   - stk_empty=1: go to DONE (short burst, no pop issued).
//   - Else, if buffer occupancy<2: assert stk_pop for exactly 1 cycle, clear timer, go to WAIT.
//   - Else (buffer full): stall in ISSUE with no pop.
//  WAIT: timer increments each cycle.
//   - stk_val=1: write stk_data into buffer, cnt+=1; go to DONE if cnt+1==len, else to ISSUE.
//   - timer==TIMEOUT with no stk_val: set err, go to DONE. A late stk_val after this is ignored.
//   - stk_val outside WAIT is ignored (not buffered, not counted).
//  DONE: done=1 for one cycle, done_cnt<=cnt, go to IDLE. cmd_busy=0 in IDLE only.
//  cmd_start while busy is dropped silently.
//  Pop-to-pop spacing is at least 2 cycles (ISSUE->WAIT->ISSUE), so the stack never sees back-to-back pops.
//  Output buffer: 2-entry FIFO, first-in first-out.
//   - m_valid = occupancy!=0; m_data = oldest entry.
//   - A word transfers when m_valid&&m_ready.
//   - A simultaneous write and read in one cycle keeps occupancy unchanged, and data order is preserved.
//   - The ISSUE gate makes overflow impossible; a write into a full buffer is an assertion failure.
//  Latency: stk_val at cycle t -> m_valid at t+1 (registered buffer output).
//  Burst end: buffered words still drain after done; the next burst may start while the buffer is non-empty.
//  Reset mid-burst: burst abandoned, buffered words lost, no done pulse.
// STRUCTURE
//  lifo_pkg: typedef enum logic[1:0] {IDLE,ISSUE,WAIT,DONE} drain_state_t; cnt/timer width helpers.
//  Sub-module out_buf2 (2-entry valid/ready FIFO, params DATA_W) instantiated once.
//  Top holds the FSM, len/cnt registers and timeout timer ($clog2(TIMEOUT+1) bits).
// TESTING
//  1 Stack holds A,B,C (responds stk_val 1 cycle after pop), cmd_len=3, m_ready=1 -> 3 pops, m_data A,B,C, done_cnt=3, err=0.
//  2 Stack holds 2 words, cmd_len=5 -> 2 pops, then stk_empty ends burst; done_cnt=2.
//  3 cmd_len=4, m_ready=0 -> exactly 2 pops, then stalls in ISSUE; raise m_ready -> remaining 2 pops, 4 words in order.
//  4 Stack never asserts stk_val, cmd_len=1 -> done at TIMEOUT+ cycles after pop, err=1, done_cnt=0; next start clears err.
//  5 cmd_len=0 -> done 2 cycles after start, no stk_pop. cmd_start while busy -> ignored.
//  6 reset_n low in WAIT -> outputs 0 immediately (async); after release, a new burst completes normally.

Source files
------------

// File: rtl/lifo_pkg.sv
// Shared types and width helpers for the LIFO burst-drain controller.
package lifo_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} drain_state_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int tmr_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/lifo_drain_ctrl_out_buf2.sv
// 2-entry FIFO between stack returns and the output stream; write-to-valid latency 1 cycle.
// Backpressure: holds words while rd_rdy=0; the writer must keep occ below 2 before writing.
module out_buf2 #(
    parameter int DATA_W = 10
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wr_vld,
    input  logic [DATA_W-1:0] wr_dat,
    output logic [1:0]        occ,
    output logic              rd_vld,
    input  logic              rd_rdy,
    output logic [DATA_W-1:0] rd_dat
);

    logic [DATA_W-1:0] mem_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        occ_q;
    logic              rd_fire;

    assign rd_fire = rd_vld && rd_rdy;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (wr_vld) begin
                mem_q[wr_ptr_q] <= wr_dat;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (rd_fire) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            // Simultaneous write and read leaves occupancy unchanged.
            case ({wr_vld, rd_fire})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign occ    = occ_q;
    assign rd_vld = (occ_q != 2'd0);
    assign rd_dat = mem_q[rd_ptr_q];

    wr_into_full_a: assert property (@(posedge clock) disable iff (!reset_n)
        !(wr_vld && occ_q == 2'd2));

endmodule

// File: rtl/lifo_drain_ctrl.sv
// Pops up to cmd_len words from an upstream stack and streams them out in pop order via out_buf2.
// Pop-to-output latency 2 cycles; pops stall while the buffer is full, burst aborts on empty or timeout.
module lifo_drain_ctrl
    import lifo_pkg::*;
#(
    parameter int DATA_W    = 10,
    parameter int LIFO_SIZE = 6,
    parameter int TIMEOUT   = 15,
    parameter int CNT_W     = cnt_width(LIFO_SIZE)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cmd_start,
    input  logic [CNT_W-1:0]  cmd_len,
    output logic              cmd_busy,
    output logic              done,
    output logic [CNT_W-1:0]  done_cnt,
    output logic              err,
    input  logic              stk_empty,
    output logic              stk_pop,
    input  logic              stk_val,
    input  logic [DATA_W-1:0] stk_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data
);

    localparam int               TMR_W   = tmr_width(TIMEOUT);
    localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(LIFO_SIZE);
    localparam logic [TMR_W-1:0] TMR_END = TMR_W'(TIMEOUT);

    drain_state_t     state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] done_cnt_q, done_cnt_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             err_q, err_d;
    logic             buf_wr;
    logic [1:0]       buf_occ;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            done_cnt_q <= '0;
            tmr_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            done_cnt_q <= done_cnt_d;
            tmr_q      <= tmr_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        tmr_d   = tmr_q;
        err_d   = err_q;
        stk_pop = 1'b0;
        buf_wr  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_start) begin
                    len_d   = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = (cmd_len == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                // Only pop when the word it returns is guaranteed a buffer slot.
                if (stk_empty) begin
                    state_d = DONE;
                end else if (buf_occ != 2'd2) begin
                    stk_pop = 1'b1;
                    tmr_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (stk_val) begin
                    buf_wr  = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = (cnt_d == len_q) ? DONE : ISSUE;
                end else if (tmr_q == TMR_END) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    tmr_d   = tmr_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        done_cnt_d = (state_d == DONE && state_q != DONE) ? cnt_d : done_cnt_q;
    end

    assign cmd_busy = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign done_cnt = done_cnt_q;
    assign err      = err_q;

    out_buf2 #(
        .DATA_W (DATA_W)
    ) u_out_buf2 (
        .clock   (clock),
        .reset_n (reset_n),
        .wr_vld  (buf_wr),
        .wr_dat  (stk_data),
        .occ     (buf_occ),
        .rd_vld  (m_valid),
        .rd_rdy  (m_ready),
        .rd_dat  (m_data)
    );

endmodule

// File: tb/tb_lifo_drain_ctrl.sv
// Bench for lifo_drain_ctrl: behavioural stack responder, table vectors, corner sequences and random bursts.
module tb_lifo_drain_ctrl;

    localparam int DATA_W    = 10;
    localparam int LIFO_SIZE = 6;
    localparam int TIMEOUT   = 15;
    localparam int CNT_W     = $clog2(LIFO_SIZE + 1);

    logic              clock     = 1'b0;
    logic              reset_n   = 1'b0;
    logic              cmd_start = 1'b0;
    logic [CNT_W-1:0]  cmd_len   = '0;
    logic              stk_empty = 1'b1;
    logic              stk_val   = 1'b0;
    logic [DATA_W-1:0] stk_data  = '0;
    logic              m_ready   = 1'b0;
    logic              cmd_busy, done, err, stk_pop, m_valid;
    logic [CNT_W-1:0]  done_cnt;
    logic [DATA_W-1:0] m_data;

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] stack[$];
    logic [DATA_W-1:0] got_q[$];
    logic [DATA_W-1:0] exp_q[$];
    int resp_dly = 1;
    int pend     = 0;
    int rdy_mode = 1;
    int pops     = 0;
    int done_n   = 0;
    int last_cnt = 0;
    int last_err = 0;
    bit prev_pop = 1'b0;

    typedef struct {
        int nw;
        int len;
        int dly;
        int rdy;
        int e_cnt;
        int e_err;
        int e_pops;
    } vec_t;

    vec_t tbl[10];

    always #5 clock = ~clock;

    lifo_drain_ctrl #(
        .DATA_W    (DATA_W),
        .LIFO_SIZE (LIFO_SIZE),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .cmd_start (cmd_start),
        .cmd_len   (cmd_len),
        .cmd_busy  (cmd_busy),
        .done      (done),
        .done_cnt  (done_cnt),
        .err       (err),
        .stk_empty (stk_empty),
        .stk_pop   (stk_pop),
        .stk_val   (stk_val),
        .stk_data  (stk_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: observe outputs at negedge, then drive stack/ready inputs just after posedge.
    task automatic tick();
        @(negedge clock);
        if (reset_n) begin
            if (stk_pop) begin
                chk("pop_spacing", int'(prev_pop), 0);
                pops++;
                pend = resp_dly;
            end
            if (done) begin
                done_n++;
                last_cnt = int'(done_cnt);
                last_err = int'(err);
            end
            if (m_valid && m_ready) got_q.push_back(m_data);
        end else begin
            pend = 0;
        end
        prev_pop = reset_n && stk_pop;
        @(posedge clock);
        #1;
        stk_val   = 1'b0;
        cmd_start = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0 && stack.size() > 0) begin
                stk_val  = 1'b1;
                stk_data = stack.pop_back();
            end
        end
        stk_empty = (stack.size() == 0);
        m_ready   = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode != 0);
    endtask

    task automatic load_stack(input int nw);
        stack.delete();
        for (int i = 0; i < nw; i++) stack.push_back(DATA_W'($urandom));
        tick();
    endtask

    // Reference: pops run from the top of the stack until len (clamped) or empty; any unanswered pop aborts.
    task automatic model_burst(input int len, input int dly,
                               output int words, output int perr, output int npops);
        int n;
        int avail;
        n     = (len > LIFO_SIZE) ? LIFO_SIZE : len;
        avail = stack.size();
        words = 0;
        perr  = 0;
        npops = 0;
        if (n == 0 || avail == 0) return;
        if (dly < 1 || dly > TIMEOUT + 1) begin
            perr  = 1;
            npops = 1;
            return;
        end
        words = (n < avail) ? n : avail;
        npops = words;
        for (int i = 0; i < words; i++) exp_q.push_back(stack[avail - 1 - i]);
    endtask

    task automatic start_burst(input int len);
        cmd_len   = CNT_W'(len);
        cmd_start = 1'b1;
        tick();
    endtask

    task automatic wait_done(input string name, input int d0);
        int n;
        n = 0;
        while (done_n == d0 && n < 400) begin
            tick();
            n++;
        end
        chk({name, "_done_seen"}, done_n - d0, 1);
    endtask

    task automatic wait_quiet();
        int n;
        n = 0;
        while (pend > 0 && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic drain_out(input string name);
        int n;
        rdy_mode = 1;
        n = 0;
        while (m_valid && n < 50) begin
            tick();
            n++;
        end
        tick();
        chk({name, "_drained"}, int'(m_valid), 0);
    endtask

    task automatic burst(input string name, input int len, input int dly,
                         input int e_cnt, input int e_err, input int e_pops);
        int p0;
        int d0;
        p0 = pops;
        d0 = done_n;
        resp_dly = dly;
        start_burst(len);
        wait_done(name, d0);
        chk({name, "_cnt"}, last_cnt, e_cnt);
        chk({name, "_err"}, last_err, e_err);
        chk({name, "_err_hold"}, int'(err), e_err);
        chk({name, "_idle"}, int'(cmd_busy), 0);
        chk({name, "_pops"}, pops - p0, e_pops);
        wait_quiet();
    endtask

    initial begin
        int w, pe, np, d0, p0, n;
        logic [DATA_W-1:0] word;

        tbl = '{
            '{3, 3,  1, 1, 3, 0, 3},
            '{2, 5,  1, 1, 2, 0, 2},
            '{7, 7,  1, 1, 6, 0, 6},
            '{1, 1,  0, 1, 0, 1, 1},
            '{3, 3,  1, 1, 3, 0, 3},
            '{3, 0,  1, 1, 0, 0, 0},
            '{0, 3,  1, 1, 0, 0, 0},
            '{2, 2, 16, 1, 2, 0, 2},
            '{2, 2, 17, 1, 0, 1, 1},
            '{5, 5,  3, 2, 5, 0, 5}
        };

        tick();
        tick();
        chk("rst_busy", int'(cmd_busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_done_cnt", int'(done_cnt), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_pop", int'(stk_pop), 0);
        chk("rst_m_valid", int'(m_valid), 0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            rdy_mode = tbl[i].rdy;
            load_stack(tbl[i].nw);
            model_burst(tbl[i].len, tbl[i].dly, w, pe, np);
            burst($sformatf("vec%0d", i), tbl[i].len, tbl[i].dly,
                  tbl[i].e_cnt, tbl[i].e_err, tbl[i].e_pops);
        end
        drain_out("vec");

        // Zero-length command: done two cycles after the strobe, nothing popped.
        load_stack(2);
        d0 = done_n;
        p0 = pops;
        start_burst(0);
        n = 1;
        while (done_n == d0 && n < 10) begin
            tick();
            n++;
        end
        chk("len0_latency", n, 2);
        chk("len0_pops", pops - p0, 0);

        // Buffer full with m_ready low: exactly two pops, then stall until the stream drains.
        rdy_mode = 0;
        load_stack(4);
        model_burst(4, 1, w, pe, np);
        d0 = done_n;
        p0 = pops;
        resp_dly = 1;
        start_burst(4);
        repeat (30) tick();
        chk("stall_pops", pops - p0, 2);
        chk("stall_busy", int'(cmd_busy), 1);
        chk("stall_m_valid", int'(m_valid), 1);
        rdy_mode = 1;
        wait_done("stall", d0);
        chk("stall_cnt", last_cnt, 4);
        chk("stall_total_pops", pops - p0, 4);
        drain_out("stall");

        // A second strobe while busy is dropped.
        load_stack(3);
        model_burst(3, 1, w, pe, np);
        d0 = done_n;
        resp_dly = 1;
        start_burst(3);
        cmd_len   = CNT_W'(1);
        cmd_start = 1'b1;
        tick();
        wait_done("drop", d0);
        repeat (5) tick();
        chk("drop_cnt", last_cnt, 3);
        chk("drop_done_pulses", done_n - d0, 1);

        // Returned word appears on the stream exactly one cycle after stk_val.
        drain_out("lat");
        load_stack(1);
        word = stack[0];
        model_burst(1, 1, w, pe, np);
        d0 = done_n;
        start_burst(1);
        n = 0;
        while (!stk_val && n < 20) begin
            tick();
            n++;
        end
        chk("lat_stk_val", int'(stk_val), 1);
        chk("lat_m_valid_t", int'(m_valid), 0);
        tick();
        chk("lat_m_valid_t1", int'(m_valid), 1);
        chk("lat_m_data_t1", int'(m_data), int'(word));
        wait_done("lat", d0);

        // Async reset while waiting on a pop, with a word held in the buffer.
        drain_out("rst");
        rdy_mode = 0;
        load_stack(2);
        resp_dly = 1;
        d0 = done_n;
        start_burst(2);
        n = 0;
        while (!m_valid && n < 20) begin
            tick();
            n++;
        end
        resp_dly = 0;
        repeat (3) tick();
        chk("rst_mid_busy_before", int'(cmd_busy), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_busy", int'(cmd_busy), 0);
        chk("rst_mid_pop", int'(stk_pop), 0);
        chk("rst_mid_m_valid", int'(m_valid), 0);
        chk("rst_mid_done_cnt", int'(done_cnt), 0);
        chk("rst_mid_err", int'(err), 0);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        chk("rst_no_done", done_n - d0, 0);
        rdy_mode = 1;
        load_stack(2);
        model_burst(2, 1, w, pe, np);
        burst("post_rst", 2, 1, 2, 0, 2);

        // Random bursts against the reference model.
        rdy_mode = 2;
        for (int i = 0; i < 30; i++) begin
            int len, dly, r;
            if (stack.size() > 10) stack.delete();
            for (int k = $urandom_range(0, 3); k > 0; k--) stack.push_back(DATA_W'($urandom));
            tick();
            len = $urandom_range(0, 7);
            r   = $urandom_range(0, 9);
            dly = (r < 7) ? $urandom_range(1, 3) : (r == 7) ? 0 : (r == 8) ? TIMEOUT + 1 : TIMEOUT + 2;
            model_burst(len, dly, w, pe, np);
            burst($sformatf("rnd%0d", i), len, dly, w, pe, np);
        end

        drain_out("final");
        chk("out_count", got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            chk($sformatf("out_word%0d", i), int'(got_q[i]), int'(exp_q[i]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
